// File: rtl/enable_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : enable_pipe_reg
// Purpose  : Elastic, bubble-collapsing register pipeline with valid/ready
//            handshakes, global enable (freeze), synchronous flush and a
//            registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module enable_pipe_reg #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // Stage state: index 0 sits at the input, DEPTH-1 drives the output.
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_occ;

  logic             w_adv;
  logic             w_carry;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_up_data [DEPTH];
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [CNT_W-1:0] w_occ_nxt;

  // Flush overrides enable: nothing may move while a flush is pending.
  assign w_adv = enable & ~flush;

  // Ready ripples from the output back: a stage can take a word if it is
  // empty or its own word is leaving this cycle.
  always_comb begin
    w_carry = out_ready;
    w_rdy   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = ~r_valid[i] | w_carry;
      w_carry  = w_rdy[i];
    end
  end

  // Upstream source of each stage: the input port for stage 0, the previous
  // stage otherwise.
  always_comb begin
    w_up_valid[0] = in_valid;
    w_up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_up_valid[i] = r_valid[i-1];
      w_up_data[i]  = r_data[i-1];
    end
  end

  // Next valid bits and their population count, so occupancy stays in step
  // with the valid bits without a separate up/down counter.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_load[i] = w_adv & w_rdy[i] & w_up_valid[i];
      if (flush) begin
        w_valid_nxt[i] = 1'b0;
      end else if (w_load[i]) begin
        w_valid_nxt[i] = 1'b1;
      end else if (w_adv & w_rdy[i] & r_valid[i]) begin
        w_valid_nxt[i] = 1'b0;
      end else begin
        w_valid_nxt[i] = r_valid[i];
      end
      w_occ_nxt = w_occ_nxt + CNT_W'(w_valid_nxt[i]);
    end
  end

  // Stage registers; data only changes on a load so drained stages keep
  // their last word.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_data[i] <= w_up_data[i];
        end
      end
    end
  end

  // in_ready is also held low while reset is asserted, since the empty
  // stages would otherwise advertise space.
  assign in_ready  = GlobalReset & w_adv & w_rdy[0];
  assign out_valid = w_adv & r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

endmodule
`default_nettype wire
